ghash_mult_sequencer: RTL and testbench

Controller that runs the GHASH accumulation Y_i = (Y_{i-1} XOR X_i) * H over a stream of DEGREE-bit blocks. It drives one shared GF(2^DEGREE) multiplier through its go/finished handshake. It sits between the block-formatting logic (AAD/ciphertext/length blocks) and the multiplier, and returns the final Y as the tag. It supervises each multiplication with a timeout.

---
 rtl/ghash_mult_sequencer.sv | 153 +++++++++++++++
 tb/tb_ghash_mult_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghash_mult_sequencer.sv
// GHASH accumulation controller: Y_i = (Y_{i-1} ^ X_i) * H over a block stream,
// sequencing one shared GF(2^DEGREE) multiplier with a completion timeout.
module ghash_mult_sequencer #(
   parameter int DEGREE  = 128,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              h_load,
   input  logic [DEGREE-1:0] h_in,
   input  logic              start,
   input  logic              abort,
   input  logic              blk_valid,
   output logic              blk_ready,
   input  logic [DEGREE-1:0] blk_data,
   input  logic              blk_last,
   output logic              tag_valid,
   output logic [DEGREE-1:0] tag,
   input  logic              tag_ack,
   output logic              busy,
   output logic              error,
   output logic [CNT_W-1:0]  blk_count,
   output logic              mult_go,
   output logic [DEGREE-1:0] mult_x,
   output logic [DEGREE-1:0] mult_y,
   input  logic [DEGREE-1:0] mult_result,
   input  logic              mult_finished
);

   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BLK,
      S_LAUNCH,
      S_WAIT_MULT,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_reg, state_next;
   logic [DEGREE-1:0] h_reg;
   logic [DEGREE-1:0] y_reg;
   logic              h_valid_reg;
   logic              last_reg;
   logic              seen_low_reg;
   logic [TMR_W-1:0]  timer_reg;

   logic load_h;
   logic start_ok;
   logic accept;
   logic complete;

   always_comb begin
      state_next = state_reg;
      load_h     = 1'b0;
      start_ok   = 1'b0;
      accept     = 1'b0;
      complete   = 1'b0;
      if (abort) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE: begin
               load_h = h_load;
               if (start && (h_valid_reg || h_load)) begin
                  start_ok   = 1'b1;
                  state_next = S_WAIT_BLK;
               end
            end
            S_WAIT_BLK: begin
               if (blk_valid) begin
                  accept     = 1'b1;
                  state_next = S_LAUNCH;
               end
            end
            S_LAUNCH: state_next = S_WAIT_MULT;
            S_WAIT_MULT: begin
               // A finished level is only trusted after it was seen low, so a
               // level left high by the previous product cannot be captured.
               if (mult_finished && seen_low_reg) begin
                  complete   = 1'b1;
                  state_next = last_reg ? S_DONE : S_WAIT_BLK;
               end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                  state_next = S_ERR;
               end
            end
            S_DONE: begin
               if (tag_ack) state_next = S_IDLE;
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
         endcase
      end
   end

   assign blk_ready = (state_reg == S_WAIT_BLK);
   assign busy      = (state_reg != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         h_reg        <= '0;
         y_reg        <= '0;
         h_valid_reg  <= 1'b0;
         last_reg     <= 1'b0;
         seen_low_reg <= 1'b0;
         timer_reg    <= '0;
         mult_go      <= 1'b0;
         mult_x       <= '0;
         mult_y       <= '0;
         tag          <= '0;
         tag_valid    <= 1'b0;
         error        <= 1'b0;
         blk_count    <= '0;
      end else begin
         state_reg <= state_next;
         mult_go   <= (state_next == S_LAUNCH);
         tag_valid <= (state_next == S_DONE);
         error     <= (state_next == S_ERR);

         if (load_h) begin
            h_reg       <= h_in;
            h_valid_reg <= 1'b1;
         end
         if (start_ok) begin
            y_reg     <= '0;
            blk_count <= '0;
         end
         // Operands are latched on accept and held untouched until the next accept.
         if (accept) begin
            mult_x   <= y_reg ^ blk_data;
            mult_y   <= h_reg;
            last_reg <= blk_last;
         end
         if (state_reg == S_LAUNCH) begin
            seen_low_reg <= 1'b0;
            timer_reg    <= '0;
         end
         if (state_reg == S_WAIT_MULT) begin
            timer_reg <= timer_reg + 1'b1;
            if (!mult_finished) seen_low_reg <= 1'b1;
         end
         if (complete) begin
            y_reg <= mult_result;
            if (blk_count != '1) blk_count <= blk_count + 1'b1;
            if (last_reg) tag <= mult_result;
         end
      end
   end

endmodule

// File: tb/tb_ghash_mult_sequencer.sv
// Bench for ghash_mult_sequencer at DEGREE=8: GF(2^8)/0x11B multiplier model,
// transaction-level reference model with a per-cycle compare, directed and random streams.
module tb_ghash_mult_sequencer;

   localparam int DEG  = 8;
   localparam int CW   = 4;
   localparam int TOUT = 16;

   logic           clk;
   logic           rst_n;
   logic           h_load;
   logic [DEG-1:0] h_in;
   logic           start;
   logic           abort;
   logic           blk_valid;
   logic           blk_ready;
   logic [DEG-1:0] blk_data;
   logic           blk_last;
   logic           tag_valid;
   logic [DEG-1:0] tag;
   logic           tag_ack;
   logic           busy;
   logic           error;
   logic [CW-1:0]  blk_count;
   logic           mult_go;
   logic [DEG-1:0] mult_x;
   logic [DEG-1:0] mult_y;
   logic [DEG-1:0] mult_result = '0;
   logic           mult_finished = 1'b0;

   ghash_mult_sequencer #(.DEGREE(DEG), .CNT_W(CW), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst_n(rst_n), .h_load(h_load), .h_in(h_in), .start(start),
      .abort(abort), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .blk_last(blk_last), .tag_valid(tag_valid),
      .tag(tag), .tag_ack(tag_ack), .busy(busy), .error(error),
      .blk_count(blk_count), .mult_go(mult_go), .mult_x(mult_x),
      .mult_y(mult_y), .mult_result(mult_result), .mult_finished(mult_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Multiplier model: 0 = finishes mm_lat cycles after go, 1 = keeps the old
   // finished level for 3 cycles then drops and rises, 2 = never finishes.
   int             mm_mode = 0;
   int             mm_lat  = 2;
   int             mm_cnt  = 0;
   bit             mm_active = 0;
   logic [DEG-1:0] mm_x = '0;
   logic [DEG-1:0] mm_y = '0;

   // Reference model state
   logic [DEG-1:0] m_h = '0;
   bit             m_hv = 0;
   logic [DEG-1:0] m_y = '0;
   int             m_acc = 0;
   bit             m_busy = 0;
   bit             go_due = 0;
   logic [DEG-1:0] exp_x = '0;
   logic [DEG-1:0] exp_h = '0;
   int             go_cnt = 0;

   function automatic logic [DEG-1:0] gmul(input logic [DEG-1:0] a, input logic [DEG-1:0] b);
      logic [DEG-1:0] p;
      logic [DEG-1:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < DEG; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[DEG-1] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      end
      return p;
   endfunction

   function automatic int sat(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   always @(negedge clk) begin
      if (mult_go) begin
         mm_x      = mult_x;
         mm_y      = mult_y;
         mm_cnt    = 0;
         mm_active = 1;
         if (mm_mode != 1) mult_finished = 1'b0;
      end else if (mm_active) begin
         mm_cnt++;
         if (mm_mode == 0 && mm_cnt == mm_lat) begin
            mult_result   = gmul(mm_x, mm_y);
            mult_finished = 1'b1;
            mm_active     = 0;
         end else if (mm_mode == 1 && mm_cnt == 3) begin
            mult_finished = 1'b0;
         end else if (mm_mode == 1 && mm_cnt == 5) begin
            mult_result   = gmul(mm_x, mm_y);
            mult_finished = 1'b1;
            mm_active     = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare process: checks outputs each cycle, then folds in this cycle's inputs.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_h = '0; m_hv = 0; m_y = '0; m_acc = 0; m_busy = 0; go_due = 0;
         end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("mult_go", 32'(mult_go), 32'(go_due));
            if (mult_go) begin
               chk("mult_x", 32'(mult_x), 32'(exp_x));
               chk("mult_y", 32'(mult_y), 32'(exp_h));
               go_cnt++;
            end
            if (blk_ready) chk("blk_count_ready", 32'(blk_count), 32'(sat(m_acc)));
            if (tag_valid) begin
               chk("tag", 32'(tag), 32'(m_y));
               chk("blk_count_done", 32'(blk_count), 32'(sat(m_acc)));
               chk("ready_in_done", 32'(blk_ready), 32'd0);
            end
            if (error) chk("error_without_hang", 32'(mm_mode), 32'd2);
            go_due = 0;
            if (abort) begin
               m_busy = 0;
            end else if (!m_busy) begin
               if (h_load) begin m_h = h_in; m_hv = 1; end
               if (start && m_hv) begin m_y = '0; m_acc = 0; m_busy = 1; end
            end else begin
               if (blk_valid && blk_ready) begin
                  exp_x  = m_y ^ blk_data;
                  exp_h  = m_h;
                  m_y    = gmul(exp_x, m_h);
                  m_acc++;
                  go_due = 1;
               end
               if (tag_valid && tag_ack) m_busy = 0;
            end
         end
      end
   endtask

   task automatic do_hload(input logic [DEG-1:0] h);
      h_load = 1'b1; h_in = h; tick(); h_load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send_block(input logic [DEG-1:0] d, input logic l, input int mode,
                             input int lat, output logic [DEG-1:0] seen_x);
      int n;
      n = 0;
      while (!blk_ready && n < 60) begin tick(); n++; end
      chk("blk_ready_wait", 32'(blk_ready), 32'd1);
      mm_mode = mode;
      mm_lat  = lat;
      blk_data = d; blk_last = l; blk_valid = 1'b1;
      tick();
      blk_valid = 1'b0;
      seen_x = mult_x;
   endtask

   task automatic wait_tag();
      int n;
      n = 0;
      while (!tag_valid && n < 200) begin tick(); n++; end
      chk("tag_valid_wait", 32'(tag_valid), 32'd1);
   endtask

   task automatic ack_tag();
      tag_ack = 1'b1; tick(); tag_ack = 1'b0;
   endtask

   initial begin
      logic [DEG-1:0] x;
      int g0;
      int nb;
      rst_n = 1'b1; h_load = 1'b0; h_in = '0; start = 1'b0; abort = 1'b0;
      blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0; tag_ack = 1'b0;
      fork
         monitor();
      join_none
      #2 rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_tag_valid", 32'(tag_valid), 32'd0);
      chk("reset_blk_count", 32'(blk_count), 32'd0);
      chk("reset_mult_x", 32'(mult_x), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single block: 0x57 * 0x03 = 0xF9
      do_hload(8'h03);
      do_start();
      send_block(8'h57, 1'b1, 0, 2, x);
      chk("t1_mult_x", 32'(x), 32'h57);
      wait_tag();
      chk("t1_tag", 32'(tag), 32'hF9);
      chk("t1_blk_count", 32'(blk_count), 32'd1);
      blk_valid = 1'b1; blk_data = 8'hFF;
      repeat (3) tick();
      chk("t1_tag_held_valid", 32'(tag_valid), 32'd1);
      chk("t1_tag_held", 32'(tag), 32'hF9);
      blk_valid = 1'b0;
      ack_tag();
      chk("t1_tag_valid_after_ack", 32'(tag_valid), 32'd0);
      chk("t1_idle_after_ack", 32'(busy), 32'd0);
      blk_valid = 1'b1;
      repeat (2) tick();
      chk("t1_idle_no_accept", 32'(busy), 32'd0);
      blk_valid = 1'b0;

      // Two blocks with H=0x02: Y1 = 0xAE, tag = 0x47; a start while busy is ignored
      g0 = go_cnt;
      do_hload(8'h02);
      do_start();
      send_block(8'h57, 1'b0, 0, 3, x);
      send_block(8'h00, 1'b1, 0, 2, x);
      chk("t2_intermediate_y", 32'(x), 32'hAE);
      do_start();
      wait_tag();
      chk("t2_tag", 32'(tag), 32'h47);
      chk("t2_blk_count", 32'(blk_count), 32'd2);
      chk("t2_go_pulses", 32'(go_cnt - g0), 32'd2);
      ack_tag();

      // Stale finished level must not be captured
      do_start();
      send_block(8'h57, 1'b0, 0, 2, x);
      send_block(8'h00, 1'b1, 1, 0, x);
      wait_tag();
      chk("t3_stale_tag", 32'(tag), 32'h47);
      ack_tag();

      // Multiplier never finishes: TIMEOUT full cycles granted after the launch cycle
      do_start();
      send_block(8'h11, 1'b1, 2, 0, x);
      repeat (TOUT) tick();
      chk("t4_error_not_yet", 32'(error), 32'd0);
      tick();
      chk("t4_error", 32'(error), 32'd1);
      chk("t4_ready_in_err", 32'(blk_ready), 32'd0);
      chk("t4_busy_in_err", 32'(busy), 32'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t4_error_cleared", 32'(error), 32'd0);
      chk("t4_idle_after_abort", 32'(busy), 32'd0);

      // Asynchronous reset in WAIT_MULT, then start needs a fresh H
      do_start();
      send_block(8'h22, 1'b0, 2, 0, x);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_mult_x", 32'(mult_x), 32'd0);
      chk("t5_rst_mult_y", 32'(mult_y), 32'd0);
      chk("t5_rst_tag", 32'(tag), 32'd0);
      chk("t5_rst_ready", 32'(blk_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mm_mode = 0;
      do_start();
      chk("t5_start_without_h", 32'(busy), 32'd0);
      do_hload(8'h03);
      do_start();
      chk("t5_start_with_h", 32'(busy), 32'd1);
      send_block(8'h57, 1'b1, 0, 3, x);
      wait_tag();
      chk("t5_tag", 32'(tag), 32'hF9);
      ack_tag();

      // blk_count saturation after 17 blocks
      do_hload(8'($urandom));
      do_start();
      for (int i = 0; i < 17; i++) send_block(8'($urandom), (i == 16), 0, 2, x);
      wait_tag();
      chk("t6_blk_count_sat", 32'(blk_count), 32'hF);
      ack_tag();

      // Random streams with ignored h_load/start while busy
      for (int s = 0; s < 25; s++) begin
         if ($urandom_range(0, 1) == 1) do_hload(8'($urandom));
         do_start();
         nb = int'($urandom_range(1, 5));
         for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_block(8'($urandom), (b == nb - 1), 0, int'($urandom_range(2, 6)), x);
            if ($urandom_range(0, 3) == 0) begin
               h_load = 1'b1; h_in = 8'($urandom); start = 1'b1;
               tick();
               h_load = 1'b0; start = 1'b0;
            end
         end
         wait_tag();
         repeat ($urandom_range(0, 3)) tick();
         ack_tag();
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
